// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one operand-2 shifter between two requesters.
// Optional statistics counters are enabled with `define SHIFT_ARB_STATS_EN.
module shift_arbiter #(
   parameter int unsigned DATA_W           = 32,
   parameter int unsigned IMM_W            = 26,
   parameter int unsigned REG_SHIFT_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_rs,
   input  logic [DATA_W-1:0] req0_rm,
   input  logic [IMM_W-1:0]  req0_imm,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_rs,
   input  logic [DATA_W-1:0] req1_rm,
   input  logic [IMM_W-1:0]  req1_imm,
   output logic [DATA_W-1:0] sh_rs,
   output logic [DATA_W-1:0] sh_rm,
   output logic [IMM_W-1:0]  sh_imm,
   input  logic [DATA_W-1:0] sh_src2,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_src2,
`ifdef SHIFT_ARB_STATS_EN
   output logic [15:0]       grant_cnt0,
   output logic [15:0]       grant_cnt1,
   output logic [15:0]       long_cnt,
`endif
   output logic              resp_id
);

   localparam int unsigned CntW = 2;

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e            state_q, state_d;
   logic              rr_q, rr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] lat_rs_q, lat_rs_d;
   logic [DATA_W-1:0] lat_rm_q, lat_rm_d;
   logic [IMM_W-1:0]  lat_imm_q, lat_imm_d;
   logic              lat_id_q, lat_id_d;
   logic              lat_long_q, lat_long_d;
   logic [DATA_W-1:0] resp_src2_q, resp_src2_d;
   logic              resp_id_q, resp_id_d;

   logic              gnt0, gnt1, accept;
   logic [IMM_W-1:0]  sel_imm;
   logic              sel_long;

   // Pointer only breaks ties; a lone valid requester is always granted.
   always_comb begin
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      if (state_q == StIdle) begin
         gnt0 = req0_valid && (!req1_valid || !rr_q);
         gnt1 = req1_valid && (!req0_valid || rr_q);
      end
      accept   = gnt0 || gnt1;
      sel_imm  = gnt1 ? req1_imm : req0_imm;
      sel_long = !sel_imm[IMM_W-1] && sel_imm[4];
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      cnt_d       = cnt_q;
      lat_rs_d    = lat_rs_q;
      lat_rm_d    = lat_rm_q;
      lat_imm_d   = lat_imm_q;
      lat_id_d    = lat_id_q;
      lat_long_d  = lat_long_q;
      resp_src2_d = resp_src2_q;
      resp_id_d   = resp_id_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               lat_rs_d   = gnt1 ? req1_rs : req0_rs;
               lat_rm_d   = gnt1 ? req1_rm : req0_rm;
               lat_imm_d  = sel_imm;
               lat_id_d   = gnt1;
               lat_long_d = sel_long;
               rr_d       = !gnt1;
               cnt_d      = sel_long ? CntW'(REG_SHIFT_CYCLES - 1) : '0;
               state_d    = StExec;
            end
         end
         StExec: begin
            if (cnt_q == '0) begin
               resp_src2_d = sh_src2;
               resp_id_d   = lat_id_q;
               state_d     = StResp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StResp: begin
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         rr_q        <= 1'b0;
         cnt_q       <= '0;
         lat_rs_q    <= '0;
         lat_rm_q    <= '0;
         lat_imm_q   <= '0;
         lat_id_q    <= 1'b0;
         lat_long_q  <= 1'b0;
         resp_src2_q <= '0;
         resp_id_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         cnt_q       <= cnt_d;
         lat_rs_q    <= lat_rs_d;
         lat_rm_q    <= lat_rm_d;
         lat_imm_q   <= lat_imm_d;
         lat_id_q    <= lat_id_d;
         lat_long_q  <= lat_long_d;
         resp_src2_q <= resp_src2_d;
         resp_id_q   <= resp_id_d;
      end
   end

   // Shifter inputs are quiet outside EXEC so the shared unit sees no toggling.
   assign sh_rs      = (state_q == StExec) ? lat_rs_q  : '0;
   assign sh_rm      = (state_q == StExec) ? lat_rm_q  : '0;
   assign sh_imm     = (state_q == StExec) ? lat_imm_q : '0;
   assign resp_valid = (state_q == StResp);
   assign resp_src2  = resp_src2_q;
   assign resp_id    = resp_id_q;

`ifdef SHIFT_ARB_STATS_EN
   logic [15:0] grant_cnt0_q, grant_cnt1_q, long_cnt_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         grant_cnt0_q <= '0;
         grant_cnt1_q <= '0;
         long_cnt_q   <= '0;
      end else begin
         if (gnt0) grant_cnt0_q <= grant_cnt0_q + 16'd1;
         if (gnt1) grant_cnt1_q <= grant_cnt1_q + 16'd1;
         if (accept && sel_long) long_cnt_q <= long_cnt_q + 16'd1;
      end
   end

   assign grant_cnt0 = grant_cnt0_q;
   assign grant_cnt1 = grant_cnt1_q;
   assign long_cnt   = long_cnt_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural operand-2 shifter model.
module tb_shift_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [31:0] req0_rs, req0_rm, req1_rs, req1_rm;
   logic [25:0] req0_imm, req1_imm;
   logic [31:0] sh_rs, sh_rm, sh_src2;
   logic [25:0] sh_imm;
   logic        resp_valid, resp_ready, resp_id;
   logic [31:0] resp_src2;
`ifdef SHIFT_ARB_STATS_EN
   logic [15:0] grant_cnt0, grant_cnt1, long_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   shift_arbiter #(.DATA_W(32), .IMM_W(26), .REG_SHIFT_CYCLES(2)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs(req0_rs),
      .req0_rm(req0_rm), .req0_imm(req0_imm),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs(req1_rs),
      .req1_rm(req1_rm), .req1_imm(req1_imm),
      .sh_rs(sh_rs), .sh_rm(sh_rm), .sh_imm(sh_imm), .sh_src2(sh_src2),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_src2(resp_src2),
`ifdef SHIFT_ARB_STATS_EN
      .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .long_cnt(long_cnt),
`endif
      .resp_id(resp_id)
   );

   // Operand-2 shifter model: rotated 8-bit immediate, or Rm shifted by imm/Rs amount.
   logic [31:0] imm32;
   logic [4:0]  rot;
   logic [7:0]  amt;
   always_comb begin
      imm32   = {24'b0, sh_imm[7:0]};
      rot     = {sh_imm[11:8], 1'b0};
      amt     = sh_imm[4] ? sh_rs[7:0] : {3'b0, sh_imm[11:7]};
      sh_src2 = '0;
      if (sh_imm[25]) begin
         sh_src2 = (imm32 >> rot) | (imm32 << (6'd32 - {1'b0, rot}));
      end else begin
         case (sh_imm[6:5])
            2'b00: sh_src2 = (amt >= 8'd32) ? 32'h0 : sh_rm << amt;
            2'b01: sh_src2 = (amt >= 8'd32) ? 32'h0 : sh_rm >> amt;
            2'b10: sh_src2 = $signed(sh_rm) >>> ((amt >= 8'd32) ? 8'd31 : amt);
            default: sh_src2 = (sh_rm >> amt[4:0]) | (sh_rm << (6'd32 - {1'b0, amt[4:0]}));
         endcase
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op from requester id and follow it to its response handshake.
   task automatic run_op(input logic id, input logic [31:0] rs, input logic [31:0] rm,
                         input logic [25:0] imm, input int lat, input logic [31:0] exp);
      if (id) begin
         req1_valid = 1'b1; req1_rs = rs; req1_rm = rm; req1_imm = imm;
      end else begin
         req0_valid = 1'b1; req0_rs = rs; req0_rm = rm; req0_imm = imm;
      end
      #1;
      chk("op_ready_own", {31'b0, id ? req1_ready : req0_ready}, 32'd1);
      chk("op_ready_other", {31'b0, id ? req0_ready : req1_ready}, 32'd0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int k = 1; k < lat; k++) begin
         chk("op_no_resp_yet", {31'b0, resp_valid}, 32'd0);
         chk("op_sh_rs", sh_rs, rs);
         chk("op_sh_rm", sh_rm, rm);
         chk("op_sh_imm", {6'b0, sh_imm}, {6'b0, imm});
         tick();
      end
      chk("op_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("op_resp_src2", resp_src2, exp);
      chk("op_resp_id", {31'b0, resp_id}, {31'b0, id});
      chk("op_sh_idle", sh_rm, 32'h0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("op_resp_done", {31'b0, resp_valid}, 32'd0);
   endtask

   initial begin
      int c;
      logic who;
      logic [31:0] held_src2;
      reset = 1'b1; resp_ready = 1'b0;
      req0_valid = 1'b0; req0_rs = '0; req0_rm = '0; req0_imm = '0;
      req1_valid = 1'b0; req1_rs = '0; req1_rm = '0; req1_imm = '0;
      tick(); tick();
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_src2", resp_src2, 32'h0);
      chk("rst_resp_id", {31'b0, resp_id}, 32'd0);
      chk("rst_sh_rm", sh_rm, 32'h0);
      reset = 1'b0;
      tick();

      // Reset while a long op is in EXEC drops it silently
      req0_valid = 1'b1; req0_rs = 32'h000C; req0_rm = 32'hC58A; req0_imm = 26'h000051A;
      #1;
      chk("mid_ready0", {31'b0, req0_ready}, 32'd1);
      tick();
      req0_valid = 1'b0;
      chk("mid_exec_sh_rm", sh_rm, 32'hC58A);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("mid_sh_rs", sh_rs, 32'h0);
      chk("mid_sh_rm", sh_rm, 32'h0);
      chk("mid_sh_imm", {6'b0, sh_imm}, 32'h0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("mid_no_resp", {31'b0, resp_valid}, 32'd0);
      end

      // Contention: both always valid, expect 0,1,0,1,...
      req0_valid = 1'b1; req0_rs = '0; req0_rm = '0; req0_imm = 26'h20000FF;
      req1_valid = 1'b1; req1_rs = '0; req1_rm = '0; req1_imm = 26'h2000001;
      for (int n = 0; n < 8; n++) begin
         #1;
         c = 0;
         while (!(req0_ready || req1_ready) && c < 20) begin
            chk("cont_not_both", {31'b0, req0_ready && req1_ready}, 32'd0);
            tick();
            c++;
         end
         chk("cont_grant_seen", {31'b0, req0_ready || req1_ready}, 32'd1);
         chk("cont_not_both", {31'b0, req0_ready && req1_ready}, 32'd0);
         who = req1_ready;
         chk("cont_grant_id", {31'b0, who}, n % 2);
         tick();
         c = 0;
         while (!resp_valid && c < 20) begin
            chk("cont_busy_ready", {31'b0, req0_ready || req1_ready}, 32'd0);
            tick();
            c++;
         end
         chk("cont_resp_seen", {31'b0, resp_valid}, 32'd1);
         chk("cont_resp_id", {31'b0, resp_id}, n % 2);
         chk("cont_resp_src2", resp_src2, (n % 2 == 1) ? 32'h1 : 32'hFF);
         resp_ready = 1'b1;
         tick();
         resp_ready = 1'b0;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      run_op(1'b0, 32'h0, 32'hC58A, 26'h20002D6, 2, 32'h6000000D);
      run_op(1'b1, 32'h0, 32'hC58A, 26'h000050A, 2, 32'h03162800);
      run_op(1'b0, 32'h000C, 32'hC58A, 26'h000051A, 3, 32'h0C58A000);

      // Backpressure: response held, no grants until the handshake
      req0_valid = 1'b1; req0_rm = 32'hC58A; req0_imm = 26'h20002D6;
      tick();
      req0_valid = 1'b0;
      tick();
      chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      held_src2 = 32'h6000000D;
      req1_valid = 1'b1; req1_rs = '0; req1_rm = 32'hC58A; req1_imm = 26'h000050A;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_src2", resp_src2, held_src2);
         chk("bp_id", {31'b0, resp_id}, 32'd0);
         chk("bp_no_ready", {31'b0, req0_ready || req1_ready}, 32'd0);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      #1;
      chk("bp_next_grant", {31'b0, req1_ready}, 32'd1);
      tick();
      req1_valid = 1'b0;
      tick();
      chk("bp_next_resp", resp_src2, 32'h03162800);
      chk("bp_next_id", {31'b0, resp_id}, 32'd1);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;

`ifdef SHIFT_ARB_STATS_EN
      chk("stat_grant0", {16'b0, grant_cnt0}, 32'd7);
      chk("stat_grant1", {16'b0, grant_cnt1}, 32'd6);
      chk("stat_long", {16'b0, long_cnt}, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one operand-2 shifter (src2shift-style unit: Rs, Rm, 26-bit imm in; src2 out) between two requesters.
- Round-robin arbitration with valid/ready handshakes.
- Register-specified shifts occupy the shifter for REG_SHIFT_CYCLES, modelling the extra Rs read cycle.
- Sits between the decode/issue ports and the single shifter instance, ahead of the ALU operand-2 input.

Parameters:
- DATA_W, 32, width of Rs, Rm and src2.
- IMM_W, 26, width of the instruction immediate field. Bit IMM_W-1 is the immediate/register select; bit 4 is the register-shift flag.
- REG_SHIFT_CYCLES, 2, shifter occupancy in cycles for register-shifted operands. Legal range 1..4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_rs  in  DATA_W  requester 0 Rs value.
- req0_rm  in  DATA_W  requester 0 Rm value.
- req0_imm  in  IMM_W  requester 0 immediate/shift field.
- req1_valid, req1_ready, req1_rs, req1_rm, req1_imm: same as requester 0, for requester 1.
- sh_rs  out  DATA_W  Rs to shared shifter.
- sh_rm  out  DATA_W  Rm to shared shifter.
- sh_imm  out  IMM_W  imm to shared shifter.
- sh_src2  in  DATA_W  combinational result from shared shifter.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_src2  out  DATA_W  registered shifter result.
- resp_id  out  1  requester that owns resp_src2.

Behaviour:
- Clock is clock. Reset is synchronous, active-high, named reset.
- States: IDLE, EXEC, RESP.
- Reset, including mid-operation, forces:
  - state=IDLE, resp_valid=0, resp_src2=0, resp_id=0.
  - sh_rs, sh_rm, sh_imm all 0.
  - round-robin pointer=0 (requester 0 preferred), exec counter=0.
  - Any in-flight operation is dropped without a response.
- Long op: imm[IMM_W-1]==0 and imm[4]==1. All other ops are short.
- IDLE, grant selection:
  - Only one valid: grant it.
  - Both valid: grant the pointer's requester.
  - req*_ready is combinational; it is high only in IDLE and only for the granted requester; never both high.
- Acceptance (valid&&ready at an edge):
  - Latch rs, rm, imm, id and long flag.
  - Pointer <= other requester.
  - Counter <= (long ? REG_SHIFT_CYCLES : 1) - 1.
  - State <= EXEC.
- EXEC:
  - sh_* are driven from the latched registers, stable for the entire occupancy.
  - Counter decrements each cycle.
  - On the cycle where counter==0: resp_src2 <= sh_src2, resp_id <= latched id, resp_valid <= 1, state <= RESP.
- RESP:
  - resp_valid=1; resp_src2 and resp_id held stable.
  - On resp_ready=1: resp_valid <= 0, state <= IDLE.
  - resp_ready ignored when resp_valid=0.
- sh_* are 0 in IDLE and RESP.
- Latency, acceptance edge to resp_valid high:
  - Short op: 2 edges.
  - Long op: REG_SHIFT_CYCLES+1 edges.
- Throughput: one operation in flight. Next grant occurs no earlier than the cycle after the RESP handshake.
- Requester rules:
  - Must hold valid and payload until ready.
  - Withdrawing valid before grant is legal; the block then grants nothing or the other requester.
- Both requesters continuously valid: grants alternate 0,1,0,1. No starvation.

Optional Feature:
- Macro SHIFT_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each, wrap modulo 2^16) and long_cnt (16 bits, counts accepted long ops).
  - All counters are 0 on reset and increment on the acceptance edge.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Bench setup: real src2shift instance attached to the sh_* ports.
- Reset while in EXEC holding a long op -> next cycle state IDLE, resp_valid=0, sh_*=0, no response ever appears for that op.
- Short immediate op: req0, rm=0xC58A, imm[25]=1, imm[11:0]=0x2D6 -> resp_valid 2 edges after acceptance, resp_src2=0x6000000D, resp_id=0.
- Short register/immediate-shift op: req1, rm=0xC58A, imm[25]=0, imm[11:0]=0x50A -> resp_src2=0x03162800, resp_id=1, latency 2.
- Long op: req0, rs=0x000C, rm=0xC58A, imm[11:0]=0x51A, REG_SHIFT_CYCLES=2 -> sh_* stable 2 cycles, resp_src2=0x0C58A000, latency 3.
- Contention: both requesters valid for 4 ops each, resp_ready=1 -> resp_id sequence 0,1,0,1,0,1,0,1; ready never high for both in one cycle.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_src2/resp_id stable, req*_ready=0 throughout, next grant one cycle after resp_ready rises.
